// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if: request/ack and result bus between four requesters and the shared Gray converter
interface gray_conv_arbiter_if #(parameter int WIDTH = 4);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] bin_in;
  logic [3:0]         ack;
  logic [WIDTH-1:0]   gray_out;
  logic               out_valid;
  logic [1:0]         out_id;
  modport master(output req, bin_in, input ack, gray_out, out_valid, out_id);
  modport slave(input req, bin_in, output ack, gray_out, out_valid, out_id);
endinterface

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin shared binary-to-Gray converter with four-phase req/ack handshake
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  gray_conv_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2;
  logic [1:0] state_q, state_d, id_q, id_d, last_q, last_d, win, idx;
  logic [WIDTH-1:0] cap_q, cap_d, gray_q, gray_d;
  logic found;
  // scan starts just after the previous winner so a re-requesting client goes to the back
  always_comb begin
    win = last_q;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    last_d = last_q;
    cap_d = cap_q;
    gray_d = gray_q;
    if (state_q == IDLE && found) begin
      state_d = GRANT;
      cap_d = bus.bin_in[win*WIDTH +: WIDTH];
      id_d = win;
      last_d = win;
    end
    if (state_q == GRANT) begin
      state_d = ACK;
      gray_d = cap_q ^ (cap_q >> 1);
    end
    if (state_q == ACK && !bus.req[id_q]) state_d = IDLE;
    if (state_q == 2'd3) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q <= '0;
      last_q <= 2'd3;
      cap_q <= '0;
      gray_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      last_q <= last_d;
      cap_q <= cap_d;
      gray_q <= gray_d;
    end
  end
  assign bus.out_valid = state_q == ACK;
  assign bus.ack = {4{state_q == ACK}} & (4'b0001 << id_q);
  assign bus.gray_out = gray_q;
  assign bus.out_id = id_q;
endmodule
